// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR controller. One shared signed multiply-accumulate
//   unit is stepped over all taps for each accepted input sample. The block
//   owns the sample delay ring and the coefficient bank.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous reset, active-low (0 = reset)
//   in_valid   in   sample offered by the source
//   in_data    in   signed sample (DW bits)
//   in_ready   out  high only while idle; a sample is taken on in_valid & in_ready
//   coef_we    in   coefficient write strobe, honoured only while idle
//   coef_addr  in   tap index of the coefficient write
//   coef_data  in   signed coefficient (CW bits)
//   out_valid  out  filter result available
//   out_data   out  signed sum_k coef[k] * x[n-k] (ACCW bits)
//   out_ready  in   consumer takes the result on out_valid & out_ready
//   busy       out  high while accumulating or holding a result
module fir_mac_sequencer #(
  parameter int TAPS = 8,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int AW   = 3,
  parameter int ACCW = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [DW-1:0]   in_data,
  output logic                   in_ready,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic signed [CW-1:0]   coef_data,
  output logic                   out_valid,
  output logic signed [ACCW-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_k;
  logic signed [DW-1:0]   r_ring [TAPS];
  logic signed [CW-1:0]   r_coef [TAPS];
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] r_out_data;
  logic                   r_out_valid;

  logic                   w_accept;
  logic                   w_coef_wr;
  logic                   w_last;
  logic [AW-1:0]          w_idx;
  logic [AW-1:0]          w_head_nxt;
  logic signed [DW+CW-1:0] w_prod;
  logic signed [ACCW-1:0] w_acc_nxt;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_coef_wr  = (r_state == S_IDLE) && coef_we;
  assign w_last     = (r_k == AW'(TAPS - 1));
  assign w_head_nxt = r_head + AW'(1);
  // Newest sample sits at head; tap k reads k positions back, wrapping on AW bits.
  assign w_idx      = r_head - r_k;
  // Size casts of signed operands sign-extend, giving a full-precision product.
  assign w_prod     = (DW+CW)'(r_ring[w_idx]) * (DW+CW)'(r_coef[r_k]);
  assign w_acc_nxt  = r_acc + ACCW'(w_prod);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> MAC on accept, MAC -> DONE after last tap, DONE -> IDLE on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_MAC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MAC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_MAC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sample ring and coefficient bank; both are written only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      for (int i = 0; i < TAPS; i++) begin
        r_ring[i] <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_head             <= w_head_nxt;
        r_ring[w_head_nxt] <= in_data;
      end
      // A write on the accepting edge lands before the first tap is read.
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_data;
      end
    end
  end

  // Accumulator, tap counter and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_k         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + AW'(1);
          if (w_last) begin
            r_out_data  <= w_acc_nxt;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  localparam int TAPS = 8;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int AW   = 3;
  localparam int ACCW = 19;
  localparam int WAIT_MAX = 3 * TAPS;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic signed [DW-1:0]   in_data;
  logic                   in_ready;
  logic                   coef_we;
  logic [AW-1:0]          coef_addr;
  logic signed [CW-1:0]   coef_data;
  logic                   out_valid;
  logic signed [ACCW-1:0] out_data;
  logic                   out_ready;
  logic                   busy;

  fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sample history (newest first) and coefficient bank.
  int hist[$];
  int mcoef[TAPS];

  typedef struct {
    int     sample;
    longint exp;
  } vec_t;

  vec_t imp[9];

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) begin
      if (k < hist.size()) s += longint'(mcoef[k]) * longint'(hist[k]);
    end
    return s;
  endfunction

  function automatic int rand_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < TAPS; k++) mcoef[k] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_busy", longint'(busy), 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    @(negedge clk);
    coef_we = 1'b0;
    mcoef[a] = d;
  endtask

  // Offers a sample until taken; optionally writes a coefficient on the same edge.
  task automatic accept(input int x, input bit cw, input int ca, input int cd);
    int n = 0;
    while (!in_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", longint'(in_ready), 1);
    if (cw) begin
      coef_we   = 1'b1;
      coef_addr = AW'(ca);
      coef_data = CW'(cd);
      mcoef[ca] = cd;
    end
    in_valid = 1'b1;
    in_data  = DW'(x);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
  endtask

  // Waits for the result; with poke set, drives junk samples and a coef write mid-pass.
  task automatic wait_out(input string name, input bit poke, output longint got);
    int lat = 0;
    while (!out_valid && lat < WAIT_MAX) begin
      if (poke && lat == 2) begin
        coef_we   = 1'b1;
        coef_addr = AW'($urandom_range(0, TAPS - 1));
        coef_data = CW'(rand_s8());
        in_valid  = 1'b1;
        in_data   = DW'(rand_s8());
      end else begin
        coef_we  = 1'b0;
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    coef_we  = 1'b0;
    in_valid = 1'b0;
    check({name, "_latency"}, longint'(lat), TAPS);
    check({name, "_busy"}, longint'(busy), 1);
    check({name, "_data"}, longint'(out_data), model_out());
    got = longint'(out_data);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid_low", longint'(out_valid), 0);
    check("hs_in_ready", longint'(in_ready), 1);
  endtask

  task automatic send(input string name, input int x, output longint got);
    accept(x, 1'b0, 0, 0);
    wait_out(name, 1'b0, got);
    handshake();
  endtask

  initial begin
    longint got;
    longint held;
    bit     seen_valid;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Impulse response: coef[k] = k+1.
    imp[0] = '{1, 1};
    for (int i = 1; i < 8; i++) imp[i] = '{0, longint'(i + 1)};
    imp[8] = '{0, 0};
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i < 9; i++) begin
      accept(imp[i].sample, 1'b0, 0, 0);
      wait_out("impulse", 1'b0, got);
      check("impulse_table", got, imp[i].exp);
      handshake();
    end

    // Extremes: full-scale products summed over all taps.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, -128);
    for (int i = 0; i < TAPS; i++) begin
      send("ext_neg", -128, got);
      if (i == TAPS - 1) check("ext_neg_final", got, 131072);
    end
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    for (int i = 0; i < TAPS; i++) begin
      send("ext_mix", -128, got);
      if (i == TAPS - 1) check("ext_mix_final", got, -130048);
    end

    // Coefficient gating during MAC, and coef write on the accepting edge.
    for (int k = 0; k < TAPS; k++) write_coef(k, rand_s8());
    accept(3, 1'b0, 0, 0);
    wait_out("mac_poke", 1'b1, got);
    handshake();
    send("after_poke", 11, got);
    accept(7, 1'b1, 0, -77);
    wait_out("coef_same_edge", 1'b0, got);
    handshake();
    accept(-5, 1'b1, 2, 99);
    wait_out("coef_same_edge2", 1'b0, got);
    handshake();

    // Ramp across the ring wrap.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, rand_s8());
    for (int x = -10; x <= 9; x++) send("ramp", x, got);

    // Backpressure: result held, source stalled, offered sample not taken.
    accept(42, 1'b0, 0, 0);
    wait_out("bp", 1'b0, got);
    held = got;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(-99);
      @(negedge clk);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_out_data", longint'(out_data), held);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    handshake();
    send("bp_after", 17, got);

    // Reset in the middle of a MAC pass.
    accept(55, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out_data", longint'(out_data), 0);
    rst = 1'b1;
    model_reset();
    seen_valid = 1'b0;
    for (int i = 0; i < TAPS + 2; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_valid", longint'(seen_valid), 0);
    accept(100, 1'b0, 0, 0);
    wait_out("coefs_zero", 1'b0, got);
    check("coefs_zero_result", got, 0);
    handshake();
    for (int k = 0; k < TAPS; k++) write_coef(k, rand_s8());
    for (int i = 0; i < 10; i++) send("post_reset", rand_s8(), got);

    // Randomized traffic with occasional coefficient updates.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(0, TAPS - 1)), rand_s8());
      send("random", rand_s8(), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
